// File: rtl/ahb_lite_master_arb_if.sv
// Bundle for the two-requester AHB-Lite master: requester handshakes plus the AHB-Lite bus.
// The master modport is the arbiter's view; slave is the environment (requesters and AHB slave).
interface ahb_lite_master_arb_if;
  logic        m0_req, m1_req;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_write, m1_write;
  logic [2:0]  m0_size, m1_size;
  logic [31:0] m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt;
  logic        m0_done, m1_done;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_err, m1_err;

  logic        hsel, hwrite, hready;
  logic [31:0] haddr, hwdata, hrdata;
  logic [1:0]  htrans;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic        hreadyout, hresp;

  modport master (
    input  m0_req, m1_req, m0_addr, m1_addr, m0_write, m1_write,
           m0_size, m1_size, m0_wdata, m1_wdata,
           hrdata, hreadyout, hresp,
    output m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err,
           hsel, hwrite, hready, haddr, hwdata, htrans, hsize, hburst, hprot
  );

  modport slave (
    output m0_req, m1_req, m0_addr, m1_addr, m0_write, m1_write,
           m0_size, m1_size, m0_wdata, m1_wdata,
           hrdata, hreadyout, hresp,
    input  m0_gnt, m1_gnt, m0_done, m1_done, m0_rdata, m1_rdata, m0_err, m1_err,
           hsel, hwrite, hready, haddr, hwdata, htrans, hsize, hburst, hprot
  );
endinterface

// File: rtl/ahb_lite_master_arb.sv
// Round-robin arbiter feeding a non-pipelined AHB-Lite master: one SINGLE transfer in flight,
// misaligned or oversize requests are rejected with gnt+done+err without touching the bus.
module ahb_lite_master_arb (
  input logic                   hclk,
  input logic                   hreset,
  ahb_lite_master_arb_if.master bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  state_t           state_reg, state_next;
  logic [1:0]       req, req_write, bad_vec;
  logic [1:0][31:0] req_addr, req_wdata;
  logic [1:0][2:0]  req_size;

  logic [1:0]       gnt_reg, gnt_next, done_reg, done_next, err_reg, err_next;
  logic [1:0][31:0] rdata_reg, rdata_next;
  logic             owner_reg, owner_next, last_reg, last_next, winner;
  logic [31:0]      wdata_reg, wdata_next;
  logic             hsel_reg, hsel_next, hwrite_reg, hwrite_next;
  logic [1:0]       htrans_reg, htrans_next;
  logic [31:0]      haddr_reg, haddr_next, hwdata_reg, hwdata_next;
  logic [2:0]       hsize_reg, hsize_next;

  assign req       = {bus.m1_req, bus.m0_req};
  assign req_write = {bus.m1_write, bus.m0_write};
  assign req_addr  = {bus.m1_addr, bus.m0_addr};
  assign req_wdata = {bus.m1_wdata, bus.m0_wdata};
  assign req_size  = {bus.m1_size, bus.m0_size};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_align
      assign bad_vec[gi] = (req_size[gi] > 3'd2) ||
                           ((req_size[gi] == 3'd1) && req_addr[gi][0]) ||
                           ((req_size[gi] == 3'd2) && (req_addr[gi][1:0] != 2'b00));
    end
  endgenerate

  // On a tie the requester that was not granted last wins; otherwise the lone requester.
  assign winner = (req == 2'b11) ? ~last_reg : req[1];

  always_comb begin
    state_next  = state_reg;
    gnt_next    = 2'b00;
    done_next   = 2'b00;
    err_next    = 2'b00;
    rdata_next  = '0;
    owner_next  = owner_reg;
    last_next   = last_reg;
    wdata_next  = wdata_reg;
    hsel_next   = hsel_reg;
    htrans_next = htrans_reg;
    haddr_next  = haddr_reg;
    hwrite_next = hwrite_reg;
    hsize_next  = hsize_reg;
    hwdata_next = hwdata_reg;
    case (state_reg)
      IDLE: begin
        if (req != 2'b00) begin
          gnt_next[winner] = 1'b1;
          last_next        = winner;
          if (bad_vec[winner]) begin
            done_next[winner] = 1'b1;
            err_next[winner]  = 1'b1;
          end else begin
            state_next  = ADDR;
            owner_next  = winner;
            wdata_next  = req_wdata[winner];
            hsel_next   = 1'b1;
            htrans_next = HTRANS_NONSEQ;
            haddr_next  = req_addr[winner];
            hwrite_next = req_write[winner];
            hsize_next  = req_size[winner];
          end
        end
      end
      ADDR: begin
        if (bus.hreadyout) begin
          state_next  = DATA;
          hsel_next   = 1'b0;
          htrans_next = HTRANS_IDLE;
          hwdata_next = hwrite_reg ? wdata_reg : 32'd0;
        end
      end
      DATA: begin
        if (bus.hreadyout) begin
          state_next           = IDLE;
          done_next[owner_reg] = 1'b1;
          err_next[owner_reg]  = bus.hresp;
          rdata_next[owner_reg] = hwrite_reg ? 32'd0 : bus.hrdata;
          hwdata_next          = 32'd0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_reg  <= IDLE;
      gnt_reg    <= 2'b00;
      done_reg   <= 2'b00;
      err_reg    <= 2'b00;
      rdata_reg  <= '0;
      owner_reg  <= 1'b0;
      last_reg   <= 1'b1;
      wdata_reg  <= 32'd0;
      hsel_reg   <= 1'b0;
      htrans_reg <= HTRANS_IDLE;
      haddr_reg  <= 32'd0;
      hwrite_reg <= 1'b0;
      hsize_reg  <= 3'd0;
      hwdata_reg <= 32'd0;
    end else begin
      state_reg  <= state_next;
      gnt_reg    <= gnt_next;
      done_reg   <= done_next;
      err_reg    <= err_next;
      rdata_reg  <= rdata_next;
      owner_reg  <= owner_next;
      last_reg   <= last_next;
      wdata_reg  <= wdata_next;
      hsel_reg   <= hsel_next;
      htrans_reg <= htrans_next;
      haddr_reg  <= haddr_next;
      hwrite_reg <= hwrite_next;
      hsize_reg  <= hsize_next;
      hwdata_reg <= hwdata_next;
    end
  end

  assign bus.m0_gnt   = gnt_reg[0];
  assign bus.m1_gnt   = gnt_reg[1];
  assign bus.m0_done  = done_reg[0];
  assign bus.m1_done  = done_reg[1];
  assign bus.m0_err   = err_reg[0];
  assign bus.m1_err   = err_reg[1];
  assign bus.m0_rdata = rdata_reg[0];
  assign bus.m1_rdata = rdata_reg[1];
  assign bus.hsel     = hsel_reg;
  assign bus.htrans   = htrans_reg;
  assign bus.haddr    = haddr_reg;
  assign bus.hwrite   = hwrite_reg;
  assign bus.hsize    = hsize_reg;
  assign bus.hwdata   = hwdata_reg;
  assign bus.hburst   = 3'b000;
  assign bus.hprot    = 4'b0011;
  assign bus.hready   = bus.hreadyout;
endmodule

// File: tb/tb_ahb_lite_master_arb.sv
// Bench for ahb_lite_master_arb: directed scenarios plus randomized transfers, with expected
// timing, bus values and arbitration order derived from the transfer rules.
module tb_ahb_lite_master_arb;
  logic hclk = 1'b0;
  logic hreset;
  int   n_checks = 0;
  int   n_fail = 0;
  logic model_last;

  ahb_lite_master_arb_if bus();
  ahb_lite_master_arb dut (.hclk(hclk), .hreset(hreset), .bus(bus));

  always #5 hclk = ~hclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] gnt_vec();
    return {30'd0, bus.m1_gnt, bus.m0_gnt};
  endfunction
  function automatic logic [31:0] done_vec();
    return {30'd0, bus.m1_done, bus.m0_done};
  endfunction
  function automatic logic [31:0] onehot(input int n);
    return (n == 0) ? 32'd1 : 32'd2;
  endfunction

  task automatic drive_req(input int n, input logic r, input logic [31:0] a, input logic w,
                           input logic [2:0] sz, input logic [31:0] wd);
    if (n == 0) begin
      bus.m0_req = r; bus.m0_addr = a; bus.m0_write = w; bus.m0_size = sz; bus.m0_wdata = wd;
    end else begin
      bus.m1_req = r; bus.m1_addr = a; bus.m1_write = w; bus.m1_size = sz; bus.m1_wdata = wd;
    end
  endtask

  task automatic drop_req(input int n);
    if (n == 0) bus.m0_req = 1'b0;
    else        bus.m1_req = 1'b0;
  endtask

  // Issue one transfer from requester n at the current negedge and follow it to completion.
  task automatic do_txn(input int n, input logic [31:0] a, input logic w, input logic [2:0] sz,
                        input logic [31:0] wd, input int aw, input int dw, input logic er,
                        input logic [31:0] rd);
    logic mis;
    mis = (sz > 3'd2) || (sz == 3'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'b00);
    drive_req(n, 1'b1, a, w, sz, wd);
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    @(negedge hclk);
    chk("gnt", gnt_vec(), onehot(n));
    model_last = n[0];
    drop_req(n);
    if (mis) begin
      chk("mis_done", done_vec(), onehot(n));
      chk("mis_err", (n == 0) ? bus.m0_err : bus.m1_err, 32'd1);
      chk("mis_htrans", bus.htrans, 32'd0);
      chk("mis_hsel", bus.hsel, 32'd0);
      $display("txn m%0d addr=%h size=%0d rejected", n, a, sz);
      return;
    end
    chk("addr_nodone", done_vec(), 32'd0);
    for (int i = 0; i <= aw; i++) begin
      if (i > 0) begin
        @(negedge hclk);
        chk("addr_gnt_low", gnt_vec(), 32'd0);
      end
      chk("addr_htrans", bus.htrans, 32'd2);
      chk("addr_hsel", bus.hsel, 32'd1);
      chk("addr_haddr", bus.haddr, a);
      chk("addr_hwrite", bus.hwrite, w);
      chk("addr_hsize", bus.hsize, sz);
      chk("addr_hwdata", bus.hwdata, 32'd0);
      bus.hreadyout = (i == aw);
    end
    for (int j = 0; j <= dw; j++) begin
      @(negedge hclk);
      chk("data_htrans", bus.htrans, 32'd0);
      chk("data_hsel", bus.hsel, 32'd0);
      chk("data_hwdata", bus.hwdata, w ? wd : 32'd0);
      chk("data_nodone", done_vec(), 32'd0);
      chk("data_haddr_hold", bus.haddr, a);
      bus.hreadyout = (j == dw);
      bus.hresp     = er && (j >= dw - 1);
      bus.hrdata    = rd;
    end
    @(negedge hclk);
    chk("done", done_vec(), onehot(n));
    chk("rdata", (n == 0) ? bus.m0_rdata : bus.m1_rdata, w ? 32'd0 : rd);
    chk("err", (n == 0) ? bus.m0_err : bus.m1_err, er);
    chk("done_hwdata", bus.hwdata, 32'd0);
    chk("done_htrans", bus.htrans, 32'd0);
    bus.hreadyout = 1'b1;
    bus.hresp     = 1'b0;
    bus.hrdata    = $urandom;
    $display("txn m%0d %s addr=%h size=%0d aw=%0d dw=%0d err=%0d done", n, w ? "wr" : "rd",
             a, sz, aw, dw, er);
  endtask

  // Both requesters raise aligned requests together; the one not granted last goes first,
  // the other keeps its request high and is served right after.
  task automatic contend();
    logic [31:0] a0, a1, d0, d1, r0, r1;
    logic w0, w1;
    int win, lose;
    a0 = $urandom & 32'hFFFF_FFFC; a1 = $urandom & 32'hFFFF_FFFC;
    d0 = $urandom; d1 = $urandom; r0 = $urandom; r1 = $urandom;
    w0 = 1'($urandom_range(0, 1)); w1 = 1'($urandom_range(0, 1));
    drive_req(0, 1'b1, a0, w0, 3'd2, d0);
    drive_req(1, 1'b1, a1, w1, 3'd2, d1);
    win  = model_last ? 0 : 1;
    lose = 1 - win;
    if (win == 0) begin
      do_txn(0, a0, w0, 3'd2, d0, 0, 0, 1'b0, r0);
      do_txn(1, a1, w1, 3'd2, d1, 0, 0, 1'b0, r1);
    end else begin
      do_txn(1, a1, w1, 3'd2, d1, 0, 0, 1'b0, r1);
      do_txn(0, a0, w0, 3'd2, d0, 0, 0, 1'b0, r0);
    end
    chk("rr_pointer_model", {31'd0, model_last}, lose);
  endtask

  initial begin
    int n, aw, dw;
    logic [31:0] a;
    logic [2:0] sz;
    logic w, er;

    hreset = 1'b1;
    bus.hreadyout = 1'b1; bus.hresp = 1'b0; bus.hrdata = 32'd0;
    drive_req(0, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    drive_req(1, 1'b0, 32'd0, 1'b0, 3'd0, 32'd0);
    model_last = 1'b1;
    @(negedge hclk);
    chk("rst_htrans", bus.htrans, 32'd0);
    chk("rst_hsel", bus.hsel, 32'd0);
    chk("rst_haddr", bus.haddr, 32'd0);
    chk("rst_hwdata", bus.hwdata, 32'd0);
    chk("rst_hwrite", bus.hwrite, 32'd0);
    chk("rst_hsize", bus.hsize, 32'd0);
    chk("rst_hburst", bus.hburst, 32'd0);
    chk("rst_hprot", bus.hprot, 32'd3);
    chk("rst_gnt", gnt_vec(), 32'd0);
    chk("rst_done", done_vec(), 32'd0);
    hreset = 1'b0;
    @(negedge hclk);

    bus.hreadyout = 1'b0; #1;
    chk("hready_lo", bus.hready, 32'd0);
    bus.hreadyout = 1'b1; #1;
    chk("hready_hi", bus.hready, 32'd1);

    do_txn(0, 32'h100, 1'b0, 3'd2, 32'd0, 0, 0, 1'b0, 32'hDEADBEEF);
    contend();
    contend();
    do_txn(1, 32'h204, 1'b1, 3'd2, 32'hA5A5A5A5, 0, 2, 1'b0, 32'h0);
    do_txn(0, 32'h300, 1'b0, 3'd2, 32'd0, 1, 1, 1'b1, 32'h12345678);
    do_txn(0, 32'h102, 1'b0, 3'd2, 32'd0, 0, 0, 1'b0, 32'd0);
    do_txn(1, 32'h401, 1'b1, 3'd1, 32'h1, 0, 0, 1'b0, 32'd0);
    do_txn(1, 32'h400, 1'b0, 3'd3, 32'd0, 0, 0, 1'b0, 32'd0);

    for (int it = 0; it < 30; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        contend();
      end else begin
        n  = $urandom_range(0, 1);
        sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        a  = $urandom;
        if ($urandom_range(0, 3) != 0) begin
          if (sz == 3'd1) a[0] = 1'b0;
          if (sz == 3'd2) a[1:0] = 2'b00;
        end
        w  = 1'($urandom_range(0, 1));
        er = ($urandom_range(0, 3) == 0);
        dw = $urandom_range(er ? 1 : 0, 3);
        aw = $urandom_range(0, 2);
        do_txn(n, a, w, sz, $urandom, aw, dw, er, $urandom);
      end
    end

    // Reset while a read sits in its data phase: the transfer must vanish without a done.
    drive_req(0, 1'b1, 32'h500, 1'b0, 3'd2, 32'd0);
    @(negedge hclk);
    drop_req(0);
    @(negedge hclk);
    chk("pre_rst_data", bus.htrans, 32'd0);
    bus.hreadyout = 1'b1;
    hreset = 1'b1;
    #1;
    chk("midrst_hsel", bus.hsel, 32'd0);
    chk("midrst_haddr", bus.haddr, 32'd0);
    chk("midrst_hwdata", bus.hwdata, 32'd0);
    chk("midrst_hprot", bus.hprot, 32'd3);
    chk("midrst_done", done_vec(), 32'd0);
    @(negedge hclk);
    hreset = 1'b0;
    model_last = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge hclk);
      chk("postrst_nodone", done_vec(), 32'd0);
      chk("postrst_htrans", bus.htrans, 32'd0);
    end
    contend();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ahb_lite_master_arb.md
AHB_LITE_MASTER_ARB -- requirements
Module: ahb_lite_master_arb

Interface
REQ-001 Parameter set SHALL be fixed (none): data/address width 32, two requesters (N = 0, 1).
REQ-002 Clocking SHALL be one clock; reset is asynchronous and active-high.
REQ-003 HCLK  in  1  sole clock, all state updates on rising edge.
REQ-004 HRESET  in  1  asynchronous active-high reset.
REQ-005 mN_req  in  1  requester N wants one transfer; held high until mN_gnt.
REQ-006 mN_addr  in  32  transfer address.
REQ-007 mN_write, mN_size, mN_wdata  in  1/3/32  direction, HSIZE encoding, write data.
REQ-008 mN_gnt  out  1  one-cycle pulse: request fields captured.
REQ-009 mN_done  out  1  one-cycle pulse: transfer finished.
REQ-010 mN_rdata, mN_err  out  32/1  read data and error flag, valid only with mN_done.
REQ-011 HSEL, HWRITE  out  1 each; HADDR, HWDATA  out  32; HTRANS  out  2; HSIZE, HBURST  out  3; HPROT  out  4: AHB-Lite master side.
REQ-012 HREADY  out  1  equals HREADYOUT combinationally (single slave, loopback).
REQ-013 HRDATA  in  32; HREADYOUT, HRESP  in  1 each: slave response.

Function
REQ-014 FSM states SHALL be IDLE, ADDR, DATA; one transfer in flight, no address/data pipelining, HBURST always 3'b000 (SINGLE), HPROT always 4'b0011.
REQ-015 IDLE: any mN_req high -> pick winner, latch its fields, pulse mN_gnt next cycle, enter ADDR.
REQ-016 Arbitration SHALL be round-robin: both requesting -> requester not granted last wins; one requesting -> it wins.
REQ-017 ADDR (registered outputs): HSEL=1, HTRANS=2'b10 (NONSEQ), HADDR/HWRITE/HSIZE from latch; exit to DATA on edge with HREADYOUT=1, else hold.
REQ-018 DATA: HTRANS=2'b00, HSEL=0, HWDATA=latched wdata if write else 0; wait for edge with HREADYOUT=1.
REQ-019 Completion (DATA, HREADYOUT=1): next cycle mN_done=1, mN_rdata=HRDATA if read else 0, mN_err=HRESP; state -> IDLE.
REQ-020 Error response: cycle with HRESP=1, HREADYOUT=0 SHALL hold DATA; completion with HRESP=1 gives mN_err=1.
REQ-021 Minimum transfer latency: req seen cycle T -> gnt/NONSEQ T+1 -> DATA T+2 -> done T+3 (zero wait states); each slave wait state adds one cycle.
REQ-022 IDLE SHALL accept a new request in the same cycle done is pulsed; req still high after done counts as a new request.
REQ-023 Misaligned (addr[0]!=0 for size 1, addr[1:0]!=0 for size 2) or mN_size>2: gnt and done+err pulse together next cycle, no bus transfer, HTRANS stays IDLE.
REQ-024 HWDATA SHALL be 0 outside DATA; HADDR/HWRITE/HSIZE hold last values outside ADDR.
REQ-025 mN_gnt, mN_done never asserted for both N in one cycle.

Reset
REQ-026 On HRESET: state IDLE, HSEL=0, HTRANS=2'b00, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=4'b0011, all gnt/done/err=0, rdata=0, last-grant pointer=1 (m0 wins first tie).
REQ-027 Reset mid-transfer SHALL abandon the transfer immediately, with no done pulse after reset release.

Verification
REQ-028 m0 read 0x100, size 2, zero wait, HRDATA=0xDEADBEEF -> NONSEQ at T+1, m0_done at T+3, m0_rdata=0xDEADBEEF, m0_err=0.
REQ-029 m0 and m1 request together, both held -> grants m0, m1, m0, m1; never simultaneous.
REQ-030 m1 write 0x204, wdata 0xA5A5A5A5, slave HREADYOUT=0 for 2 DATA cycles -> HWDATA stable 0xA5A5A5A5 3 cycles, m1_done at T+5.
REQ-031 Slave two-cycle ERROR (HRESP=1 with HREADYOUT 0 then 1) on m0 read -> m0_done with m0_err=1.
REQ-032 m0 addr 0x102, size 2 -> m0_gnt and m0_done with m0_err=1 at T+1, HTRANS remains 2'b00.
REQ-033 HRESET asserted during DATA -> all outputs at reset values same cycle, no done after release.
